// File: rtl/dbg_cmd_dispatch_pkg.sv
// Shared types and helpers for the sysclk-side debug command dispatcher.
package dbg_pkg;

  // Dispatcher states, kept as plain constants for legacy tooling.
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t WAIT = 1'b1;

  // Width needed to hold a channel index; never below one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/dbg_cmd_dispatch_if.sv
// Command/status bundle between the TCK-side debug slave and the sysclk dispatcher.
interface dbg_cmd_dispatch_if #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned NUM_CH   = 4
);
  logic                uir_tgl;
  logic                udr_tgl;
  logic [IR_WIDTH-1:0] ir_in;
  logic [DR_WIDTH-1:0] sr;
  logic [NUM_CH-1:0]   ch_busy;
  logic                overrun_clr;
  logic [DR_WIDTH-1:0] jdo;
  logic [IR_WIDTH-1:0] ir_latched;
  logic [NUM_CH-1:0]   take_action;
  logic [NUM_CH-1:0]   take_no_action;
  logic                cmd_pending;
  logic                overrun;
  logic                invalid;

  modport master (
    output uir_tgl, udr_tgl, ir_in, sr, ch_busy, overrun_clr,
    input  jdo, ir_latched, take_action, take_no_action, cmd_pending, overrun, invalid
  );

  modport slave (
    input  uir_tgl, udr_tgl, ir_in, sr, ch_busy, overrun_clr,
    output jdo, ir_latched, take_action, take_no_action, cmd_pending, overrun, invalid
  );
endinterface

// File: rtl/dbg_cmd_dispatch_tgl_sync.sv
// Toggle synchroniser with edge detect; suppresses edges for SYNC_STAGES cycles after reset.
module dbg_tgl_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tgl,
  output logic edge_c
);
  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       warm_q;
  logic                   warming;

  assign warming = (warm_q != '0);

  // During warm-up prev follows the value the last stage is about to take, so a
  // toggle that was already 1 at reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      warm_q <= CNT_W'(SYNC_STAGES);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
      prev_q <= warming ? sync_q[SYNC_STAGES-2] : sync_q[SYNC_STAGES-1];
      if (warming) warm_q <= warm_q - CNT_W'(1);
    end
  end

  assign edge_c = (sync_q[SYNC_STAGES-1] ^ prev_q) & ~warming;

endmodule

// File: rtl/dbg_cmd_dispatch.sv
// Sysclk-side debug command dispatcher: captures IR/DR updates and issues per-channel pulses.
module dbg_cmd_dispatch
  import dbg_pkg::*;
#(
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned DR_WIDTH    = 38,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ACT_BIT     = 37,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  dbg_cmd_dispatch_if.slave bus
);
  localparam int unsigned CH_W = ch_w(NUM_CH);

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic                kind;
    logic [DR_WIDTH-1:0] data;
  } hold_t;

  state_t              state_q, state_d;
  hold_t               hold_q, hold_d;
  logic [DR_WIDTH-1:0] jdo_q, jdo_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [NUM_CH-1:0]   act_q, act_d, nact_q, nact_d, sel_c;
  logic                ov_q, ov_d, inv_q, inv_d;
  logic                uir_edge_c, udr_edge_c, busy_c, ch_ok_c;

  dbg_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset(reset), .tgl(bus.uir_tgl), .edge_c(uir_edge_c)
  );

  dbg_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset(reset), .tgl(bus.udr_tgl), .edge_c(udr_edge_c)
  );

  // One-hot select of the held command's channel.
  always_comb begin
    sel_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) sel_c[c] = (32'(hold_q.ch) == c);
  end

  assign busy_c  = |(sel_c & bus.ch_busy);
  assign ch_ok_c = (32'(ir_q) < NUM_CH);

  // Next state; a capture in the issue cycle overwrites the hold after the issue fires.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    jdo_d   = jdo_q;
    ir_d    = ir_q;
    act_d   = '0;
    nact_d  = '0;
    ov_d    = ov_q;
    inv_d   = inv_q;

    if (bus.overrun_clr) begin
      ov_d  = 1'b0;
      inv_d = 1'b0;
    end

    if (uir_edge_c) ir_d = bus.ir_in;

    if (state_q == WAIT && !busy_c) begin
      jdo_d   = hold_q.data;
      act_d   = hold_q.kind ? sel_c : '0;
      nact_d  = hold_q.kind ? '0 : sel_c;
      state_d = IDLE;
    end

    if (udr_edge_c) begin
      if (ch_ok_c) begin
        hold_d.ch   = CH_W'(ir_q);
        hold_d.kind = bus.sr[ACT_BIT];
        hold_d.data = bus.sr;
        if (state_q == WAIT) ov_d = 1'b1;
        state_d = WAIT;
      end else begin
        inv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      jdo_q   <= '0;
      ir_q    <= '0;
      act_q   <= '0;
      nact_q  <= '0;
      ov_q    <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      jdo_q   <= jdo_d;
      ir_q    <= ir_d;
      act_q   <= act_d;
      nact_q  <= nact_d;
      ov_q    <= ov_d;
      inv_q   <= inv_d;
    end
  end

  assign bus.jdo            = jdo_q;
  assign bus.ir_latched     = ir_q;
  assign bus.take_action    = act_q;
  assign bus.take_no_action = nact_q;
  assign bus.cmd_pending    = (state_q == WAIT);
  assign bus.overrun        = ov_q;
  assign bus.invalid        = inv_q;

endmodule

// File: tb/tb_dbg_cmd_dispatch.sv
// Bench for dbg_cmd_dispatch: 4-channel and 3-channel instances against a transaction-level model.
module tb_dbg_cmd_dispatch;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        uir_v = 1'b0, udr_v = 1'b0, ovclr_v = 1'b0;
  logic [1:0]  ir_v = '0;
  logic [37:0] sr_v = '0;
  logic [3:0]  busy_v = '0;

  dbg_cmd_dispatch_if #(.IR_WIDTH(2), .DR_WIDTH(38), .NUM_CH(4)) bus0 ();
  dbg_cmd_dispatch_if #(.IR_WIDTH(2), .DR_WIDTH(38), .NUM_CH(3)) bus1 ();

  assign bus0.uir_tgl = uir_v;   assign bus1.uir_tgl = uir_v;
  assign bus0.udr_tgl = udr_v;   assign bus1.udr_tgl = udr_v;
  assign bus0.ir_in   = ir_v;    assign bus1.ir_in   = ir_v;
  assign bus0.sr      = sr_v;    assign bus1.sr      = sr_v;
  assign bus0.ch_busy = busy_v;  assign bus1.ch_busy = busy_v[2:0];
  assign bus0.overrun_clr = ovclr_v;
  assign bus1.overrun_clr = ovclr_v;

  dbg_cmd_dispatch #(.IR_WIDTH(2), .DR_WIDTH(38), .NUM_CH(4), .ACT_BIT(37), .SYNC_STAGES(SYNC))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dbg_cmd_dispatch #(.IR_WIDTH(2), .DR_WIDTH(38), .NUM_CH(3), .ACT_BIT(37), .SYNC_STAGES(SYNC))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Model: a toggle flipped before edge E lands at edge E+SYNC; a held command
  // issues on the first later edge whose sampled busy bit for its channel is low.
  typedef struct { int unsigned at; logic [37:0] val; } evt_t;
  evt_t        uq[$], dq[$];
  int unsigned ecnt = 0;
  int unsigned nch[2];
  logic        m_pend[2], m_kind[2], m_ov[2], m_inv[2];
  logic [1:0]  m_ch[2], m_ir[2];
  logic [37:0] m_data[2], e_jdo[2];
  logic [3:0]  e_ta[2], e_tna[2];

  int checks = 0;
  int errors = 0;

  task automatic model_edge();
    logic uh, dh, was;
    logic [37:0] uv, dv;
    uv = '0; dv = '0;
    ecnt++;
    uh = (uq.size() > 0) && (uq[0].at == ecnt);
    dh = (dq.size() > 0) && (dq[0].at == ecnt);
    if (uh) begin uv = uq[0].val; void'(uq.pop_front()); end
    if (dh) begin dv = dq[0].val; void'(dq.pop_front()); end
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pend[i] = 0; m_kind[i] = 0; m_ov[i] = 0; m_inv[i] = 0;
        m_ch[i] = '0; m_ir[i] = '0; m_data[i] = '0; e_jdo[i] = '0;
        e_ta[i] = '0; e_tna[i] = '0;
        continue;
      end
      e_ta[i] = '0; e_tna[i] = '0;
      was = m_pend[i];
      if (m_pend[i] && !busy_v[m_ch[i]]) begin
        e_jdo[i] = m_data[i];
        if (m_kind[i]) e_ta[i] = 4'(1) << m_ch[i];
        else           e_tna[i] = 4'(1) << m_ch[i];
        m_pend[i] = 0;
      end
      if (ovclr_v) begin m_ov[i] = 0; m_inv[i] = 0; end
      if (dh) begin
        if (32'(m_ir[i]) >= nch[i]) m_inv[i] = 1;
        else begin
          if (was) m_ov[i] = 1;
          m_pend[i] = 1; m_ch[i] = m_ir[i]; m_kind[i] = dv[37]; m_data[i] = dv;
        end
      end
      if (uh) m_ir[i] = uv[1:0];
    end
    if (reset) begin uq.delete(); dq.delete(); end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("jdo0",  64'(bus0.jdo),            64'(e_jdo[0]));
    chk("ir0",   64'(bus0.ir_latched),     64'(m_ir[0]));
    chk("ta0",   64'(bus0.take_action),    64'(e_ta[0]));
    chk("tna0",  64'(bus0.take_no_action), 64'(e_tna[0]));
    chk("pend0", 64'(bus0.cmd_pending),    64'(m_pend[0]));
    chk("ov0",   64'(bus0.overrun),        64'(m_ov[0]));
    chk("inv0",  64'(bus0.invalid),        64'(m_inv[0]));
    chk("jdo1",  64'(bus1.jdo),            64'(e_jdo[1]));
    chk("ir1",   64'(bus1.ir_latched),     64'(m_ir[1]));
    chk("ta1",   64'(bus1.take_action),    64'(e_ta[1][2:0]));
    chk("tna1",  64'(bus1.take_no_action), 64'(e_tna[1][2:0]));
    chk("pend1", 64'(bus1.cmd_pending),    64'(m_pend[1]));
    chk("ov1",   64'(bus1.overrun),        64'(m_ov[1]));
    chk("inv1",  64'(bus1.invalid),        64'(m_inv[1]));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic flip_uir(input logic [1:0] ir);
    ir_v  = ir;
    uir_v = ~uir_v;
    uq.push_back('{at: ecnt + 1 + SYNC, val: 38'(ir)});
  endtask

  task automatic flip_udr(input logic [37:0] val);
    sr_v  = val;
    udr_v = ~udr_v;
    dq.push_back('{at: ecnt + 1 + SYNC, val: val});
  endtask

  initial begin
    nch[0] = 4; nch[1] = 3;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_kind[i] = 0; m_ov[i] = 0; m_inv[i] = 0; m_ch[i] = '0;
      m_ir[i] = '0; m_data[i] = '0; e_jdo[i] = '0; e_ta[i] = '0; e_tna[i] = '0;
    end

    // Reset state
    cyc(3);
    chk("rst_jdo", 64'(bus0.jdo), 64'h0);
    chk("rst_pend", 64'(bus0.cmd_pending), 64'h0);
    reset = 1'b0;
    cyc(5);

    // Basic issue to channel 2, fixed latency
    flip_uir(2'd2);
    cyc(5);
    flip_udr(38'h20_0000_1234);
    cyc(3);
    chk("basic_early", 64'(bus0.take_action), 64'h0);
    cyc(1);
    chk("basic_ta", 64'(bus0.take_action), 64'b0100);
    chk("basic_tna", 64'(bus0.take_no_action), 64'h0);
    chk("basic_jdo", 64'(bus0.jdo), 64'h20_0000_1234);
    cyc(1);
    chk("basic_once", 64'(bus0.take_action), 64'h0);
    cyc(3);

    // Back-pressure on channel 1
    busy_v = 4'b0010;
    flip_uir(2'd1);
    cyc(5);
    flip_udr(38'h00_dead_beef);
    cyc(10);
    chk("bp_pend", 64'(bus0.cmd_pending), 64'h1);
    chk("bp_jdo_held", 64'(bus0.jdo), 64'h20_0000_1234);
    busy_v = 4'b0000;
    cyc(1);
    chk("bp_tna", 64'(bus0.take_no_action), 64'b0010);
    chk("bp_jdo", 64'(bus0.jdo), 64'h00_dead_beef);
    cyc(3);

    // Overrun while waiting on busy channel 0
    flip_uir(2'd0);
    cyc(5);
    busy_v = 4'b0001;
    flip_udr(38'h20_0000_0007);
    cyc(6);
    flip_udr(38'h5);
    cyc(6);
    chk("ovr_flag", 64'(bus0.overrun), 64'h1);
    busy_v = 4'b0000;
    cyc(1);
    chk("ovr_tna", 64'(bus0.take_no_action), 64'b0001);
    chk("ovr_jdo", 64'(bus0.jdo), 64'h5);
    cyc(3);
    ovclr_v = 1'b1;
    cyc(1);
    ovclr_v = 1'b0;
    chk("ovr_clr", 64'(bus0.overrun), 64'h0);
    cyc(2);

    // Channel 3: valid on the 4-channel instance, invalid on the 3-channel one
    flip_uir(2'd3);
    cyc(5);
    flip_udr(38'h20_1111_2222);
    cyc(6);
    chk("inv_flag", 64'(bus1.invalid), 64'h1);
    chk("inv_pend", 64'(bus1.cmd_pending), 64'h0);
    chk("inv_jdo", 64'(bus1.jdo), 64'h5);
    ovclr_v = 1'b1;
    cyc(1);
    ovclr_v = 1'b0;
    cyc(2);

    // Toggle high across reset release must not produce a command
    reset = 1'b1;
    udr_v = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(20);
    chk("art_pend", 64'(bus0.cmd_pending), 64'h0);

    // Reset while a command waits discards it
    busy_v = 4'b0001;
    flip_udr(38'h20_0000_00aa);
    cyc(6);
    chk("rw_pend", 64'(bus0.cmd_pending), 64'h1);
    reset  = 1'b1;
    busy_v = 4'b0000;
    cyc(2);
    reset = 1'b0;
    chk("rw_jdo", 64'(bus0.jdo), 64'h0);
    chk("rw_pend0", 64'(bus0.cmd_pending), 64'h0);
    cyc(10);

    // Simultaneous IR and DR updates: capture uses the old IR
    flip_uir(2'd1);
    flip_udr(38'h20_0000_0c0c);
    cyc(4);
    chk("same_ta", 64'(bus0.take_action), 64'b0001);
    cyc(2);
    flip_udr(38'h20_0000_0d0d);
    cyc(4);
    chk("same_next", 64'(bus0.take_action), 64'b0010);
    cyc(3);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      int unsigned gap;
      if ($urandom_range(0, 1) == 1) begin
        flip_uir(2'($urandom_range(0, 3)));
        cyc(int'($urandom_range(0, 5)));
      end
      flip_udr(38'({$urandom, $urandom}));
      gap = $urandom_range(5, 12);
      for (int k = 0; k < int'(gap); k++) begin
        busy_v  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
        ovclr_v = ($urandom_range(0, 15) == 0);
        cyc(1);
      end
      busy_v  = 4'b0000;
      ovclr_v = 1'b0;
      if ($urandom_range(0, 3) == 0) cyc(6);
    end
    cyc(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbg_cmd_dispatch.md
Name: dbg_cmd_dispatch

Overview:
System-clock-side command dispatcher for the on-chip debug slave. It is the parametrised successor of the fixed 2-bit-IR / 38-bit-DR sysclk bridge. It receives update-IR and update-DR toggles from the TCK domain, captures the quasi-static IR and shift-register contents, and decodes them into per-channel take_action / take_no_action pulses. Compared with the fixed bridge it adds generic IR/DR width and channel count, back-pressure per channel (ch_busy) with a one-deep hold register, sticky overrun/invalid flags, and post-reset edge suppression.

Parameters:
IR_WIDTH, 2, width of ir_in / ir_latched; must be >= clog2(NUM_CH)
DR_WIDTH, 38, width of sr / jdo
NUM_CH, 4, number of action channels (channel index = ir_latched value)
ACT_BIT, 37, sr bit selecting take_action (1) vs take_no_action (0); < DR_WIDTH
SYNC_STAGES, 2, synchroniser depth for each toggle, >= 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
uir_tgl  in  1  TCK-domain toggle, flips once per update-IR
udr_tgl  in  1  TCK-domain toggle, flips once per update-DR
ir_in  in  IR_WIDTH  TCK-domain IR; stable for >= SYNC_STAGES+2 clk after uir_tgl flips
sr  in  DR_WIDTH  TCK-domain shift register; stable for >= SYNC_STAGES+2 clk after udr_tgl flips
ch_busy  in  NUM_CH  per-channel consumer busy; command to channel c held while ch_busy[c]=1
overrun_clr  in  1  clears overrun and invalid flags
jdo  out  DR_WIDTH  data of the most recently issued command
ir_latched  out  IR_WIDTH  IR captured at last update-IR
take_action  out  NUM_CH  one-cycle pulse, one-hot or zero
take_no_action  out  NUM_CH  one-cycle pulse, one-hot or zero
cmd_pending  out  1  hold register occupied (state WAIT)
overrun  out  1  sticky: a command was replaced while pending
invalid  out  1  sticky: command dropped, channel index >= NUM_CH

Behaviour:
- Reset: all sync flops, prev flops, jdo, ir_latched, take_action, take_no_action, cmd_pending, overrun and invalid go to 0. FSM goes to IDLE. Warm-up counter loads SYNC_STAGES.
- Synchroniser: each toggle passes through a SYNC_STAGES flop chain; prev <= last stage every cycle; edge = last ^ prev.
- Warm-up: while the counter is nonzero, edges are ignored and the counter decrements. This prevents a spurious edge when a toggle is 1 at reset release.
- uir edge: ir_latched <= ir_in at the next clk edge.
- udr edge: hold <= {ch = ir_latched (the value before any same-cycle uir update), kind = sr[ACT_BIT], data = sr}. FSM goes to WAIT.
- Simultaneous uir and udr edges: the udr capture uses the old ir_latched; the new IR applies from the next command.
- Channel check at capture: if ch >= NUM_CH, the command is dropped, invalid <= 1 and the FSM does not enter WAIT.
- FSM IDLE: waits for a valid udr edge.
- FSM WAIT (cmd_pending=1): each cycle, if ch_busy[hold.ch]=0, register the issue and return to IDLE.
  - Issue: jdo <= hold.data. take_action[ch] <= kind, or take_no_action[ch] <= ~kind, for exactly one cycle.
  - jdo holds its value until the next issue.
- Latency: number the first clk edge that samples the new udr_tgl value as edge 0. With no back-pressure, the pulse and new jdo are visible in the cycle after edge SYNC_STAGES+1.
- New udr edge while in WAIT (including the cycle the issue fires): the hold is overwritten with the new command, overrun <= 1, and the FSM stays in or re-enters WAIT. A command that fired in that same cycle still pulses.
- overrun_clr clears both flags. If overrun_clr and a set event occur in the same cycle, set wins.
- Reset mid-WAIT discards the held command; no pulse is produced.

Decomposition:
- Package dbg_pkg:
  - constant CH_W = clog2(NUM_CH) helper function
  - typedef of the state enum {IDLE, WAIT}
  - hold-record typedef {ch, kind, data}
- Sub-module dbg_tgl_sync: SYNC_STAGES flops, prev flop, warm-up gating, one-cycle edge output. Instantiated twice.

Test Plan:
- Basic issue: reset; ir_in=2, flip uir; sr=38'h20_0000_1234 (bit37=1), flip udr, ch_busy=0 -> take_action=4'b0100 for one cycle after edge 3 (SYNC_STAGES=2); jdo=38'h20_0000_1234; take_no_action=0.
- Back-pressure: ch_busy[1]=1 for 10 cycles, command to ch 1 with bit37=0 -> cmd_pending=1 throughout; take_no_action=4'b0010 in the cycle after ch_busy[1] falls; jdo is unchanged before that.
- Overrun: while WAIT on busy ch 0, send a second command (sr=5) -> overrun=1, only one pulse and jdo=5 after release; overrun_clr -> overrun=0.
- Invalid: NUM_CH=3, ir=3, flip udr -> no pulse, invalid=1, cmd_pending=0.
- Reset artefacts: hold udr_tgl=1 through reset release -> no pulse in 20 cycles. Also assert reset while in WAIT -> no pulse, all outputs 0.
- Same-cycle edges: uir (ir 0->1) and udr flip together -> pulse on ch 0; the next udr pulses ch 1.
